// File: rtl/nios_with_onchip_sdram_cpu_dct_pack_ctrl_if.sv
// Bundle of trace-atom input, flush request and frame output signals
// for the data-trace atom packer. The master side produces atoms and
// consumes frames; the slave side is the packer itself.
interface nios_with_onchip_sdram_cpu_dct_pack_ctrl_if;
    logic        trc_on;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        atom_ready;
    logic        flush_req;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic        frame_ready;
    logic [33:0] frame_data;
    logic        overflow;

    modport master (
        output trc_on,
        output atom_valid,
        output atom,
        output flush_req,
        output frame_ready,
        input  atom_ready,
        input  dct_buffer,
        input  dct_count,
        input  frame_valid,
        input  frame_data,
        input  overflow
    );

    modport slave (
        input  trc_on,
        input  atom_valid,
        input  atom,
        input  flush_req,
        input  frame_ready,
        output atom_ready,
        output dct_buffer,
        output dct_count,
        output frame_valid,
        output frame_data,
        output overflow
    );
endinterface

// File: rtl/nios_with_onchip_sdram_cpu_dct_pack_ctrl.sv
// Data-trace atom packer: collects up to 15 two-bit atoms into a 30-bit
// buffer and presents {count, buffer} as a frame when the buffer is full,
// on an explicit flush, when tracing is disabled, or after TIMEOUT idle
// cycles. Atoms offered while a frame is pending are dropped and flagged
// in a sticky overflow bit.
module nios_with_onchip_sdram_cpu_dct_pack_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic clk,
    input logic reset,
    nios_with_onchip_sdram_cpu_dct_pack_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Idle counter value at which a partial frame is forced out; hitting it
    // on the cycle's increment yields frame_valid exactly TIMEOUT cycles
    // after the last accept.
    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [29:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  idle_q, idle_d;
    logic        ovf_q, ovf_d;

    logic        accept;
    logic [7:0]  idle_inc;
    logic [4:0]  slot_sh;
    logic [29:0] slot_val;

    // Ready is withheld during reset and while a frame waits downstream.
    assign bus.atom_ready = bus.trc_on & (state_q != EMIT) & ~reset;
    assign accept         = bus.atom_valid & bus.atom_ready;

    // New atom positioned in the next free slot; unused slots are always
    // zero, so OR-ing it in is equivalent to a slot write.
    assign slot_sh  = {cnt_q, 1'b0};
    assign slot_val = {28'd0, bus.atom} << slot_sh;
    assign idle_inc = idle_q + 8'd1;

    // Next-state, buffer and flag update logic.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        ovf_d   = ovf_q;

        if (accept) begin
            buf_d = buf_q | slot_val;
            cnt_d = cnt_q + 4'd1;
        end

        unique case (state_q)
            IDLE: begin
                // flush_req is meaningless with nothing buffered.
                idle_d = '0;
                if (accept) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                idle_d = accept ? 8'd0 : idle_inc;
                if (accept && (cnt_q == 4'd14)) begin
                    // This accept fills the 15th slot; there is no 16th.
                    state_d = EMIT;
                end else if (bus.flush_req || !bus.trc_on) begin
                    // A same-cycle accept is already folded into buf_d.
                    state_d = EMIT;
                end else if (!accept && (idle_inc == IDLE_LIMIT)) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                idle_d = '0;
                if (bus.atom_valid && bus.trc_on) begin
                    ovf_d = 1'b1;
                end
                if (bus.frame_ready) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                buf_d   = '0;
                cnt_d   = '0;
                idle_d  = '0;
            end
        endcase
    end

    // State register; reset discards any pending frame and the sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.frame_valid = (state_q == EMIT);
    assign bus.dct_buffer  = buf_q;
    assign bus.dct_count   = cnt_q;
    assign bus.frame_data  = {cnt_q, buf_q};
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_nios_with_onchip_sdram_cpu_dct_pack_ctrl.sv
// Bench for the data-trace atom packer: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_nios_with_onchip_sdram_cpu_dct_pack_ctrl;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    nios_with_onchip_sdram_cpu_dct_pack_ctrl_if bus ();

    nios_with_onchip_sdram_cpu_dct_pack_ctrl #(.TIMEOUT(TO)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: pending atoms as a queue, a frame-pending flag,
    // idle-cycle count and sticky overflow.
    logic [1:0] m_q[$];
    bit         m_emit = 1'b0;
    bit         m_ovf  = 1'b0;
    int         m_idle = 0;

    function automatic logic [29:0] m_buf();
        longint unsigned v;
        v = 0;
        foreach (m_q[i]) v += longint'(m_q[i]) * (longint'(1) << (2 * i));
        return v[29:0];
    endfunction

    function automatic logic [70:0] m_expect();
        logic [29:0] b;
        logic [3:0]  c;
        logic        rdy;
        b   = m_buf();
        c   = 4'(m_q.size());
        rdy = !reset && bus.trc_on && !m_emit;
        return {m_emit, m_ovf, rdy, c, b, c, b};
    endfunction

    function automatic logic [70:0] dut_obs();
        return {bus.frame_valid, bus.overflow, bus.atom_ready, bus.dct_count,
                bus.dct_buffer, bus.frame_data};
    endfunction

    task automatic model_step();
        bit acc;
        bit was_empty;
        if (reset) begin
            m_q.delete();
            m_emit = 1'b0;
            m_ovf  = 1'b0;
            m_idle = 0;
        end else if (m_emit) begin
            if (bus.atom_valid && bus.trc_on) m_ovf = 1'b1;
            if (bus.frame_ready) begin
                m_q.delete();
                m_emit = 1'b0;
            end
            m_idle = 0;
        end else begin
            acc       = bus.trc_on && bus.atom_valid;
            was_empty = (m_q.size() == 0);
            if (acc) m_q.push_back(bus.atom);
            if (was_empty || acc) m_idle = 0;
            else m_idle++;
            if (!was_empty) begin
                if (m_q.size() == 15 || bus.flush_req || !bus.trc_on ||
                    (!acc && m_idle == TO - 1))
                    m_emit = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic tr, input logic av, input logic [1:0] a,
                         input logic fl, input logic fr);
        bus.trc_on      = tr;
        bus.atom_valid  = av;
        bus.atom        = a;
        bus.flush_req   = fl;
        bus.frame_ready = fr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (bus.atom_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_atom_ready observed=%b expected=0", bus.atom_ready);
        end
        tick();
        tick();
        n_cmp++;
        if ({bus.frame_valid, bus.overflow, bus.dct_count, bus.dct_buffer} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_state observed=%h expected=0",
                     {bus.frame_valid, bus.overflow, bus.dct_count, bus.dct_buffer});
        end
        reset = 1'b0;
    endtask

    task automatic test_full_frame();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
            #1;
            n_cmp++;
            if (dut_obs() !== m_expect()) begin
                n_bad++;
                $display("FAIL full_fill[%0d] observed=%h expected=%h", i, dut_obs(), m_expect());
            end
            tick();
        end
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        #1;
        n_cmp++;
        if ({bus.frame_valid, bus.frame_data} !== {1'b1, 4'd15, 30'h15555555}) begin
            n_bad++;
            $display("FAIL full_frame observed=%h expected=%h",
                     {bus.frame_valid, bus.frame_data}, {1'b1, 4'd15, 30'h15555555});
        end
        tick();
        n_cmp++;
        if ({bus.frame_valid, bus.dct_count, bus.dct_buffer} !== 35'd0) begin
            n_bad++;
            $display("FAIL full_handshake observed=%h expected=0",
                     {bus.frame_valid, bus.dct_count, bus.dct_buffer});
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0); #1; tick();
        drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0); #1; tick();
        drive(1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (dut_obs() !== m_expect()) begin
            n_bad++;
            $display("FAIL flush_pre observed=%h expected=%h", dut_obs(), m_expect());
        end
        tick();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if ({bus.frame_valid, bus.frame_data} !== {1'b1, 4'd3, 30'h0000001B}) begin
            n_bad++;
            $display("FAIL flush_frame observed=%h expected=%h",
                     {bus.frame_valid, bus.frame_data}, {1'b1, 4'd3, 30'h0000001B});
        end
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (dut_obs() !== m_expect()) begin
            n_bad++;
            $display("FAIL flush_done observed=%h expected=%h", dut_obs(), m_expect());
        end
    endtask

    task automatic test_backpressure();
        logic [29:0] acc_buf;
        logic [1:0]  a;
        do_reset();
        acc_buf = '0;
        for (int i = 0; i < 15; i++) begin
            a = 2'($urandom_range(0, 3));
            acc_buf[2 * i +: 2] = a;
            drive(1'b1, 1'b1, a, 1'b0, 1'b0);
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
            #1;
            n_cmp++;
            if ({bus.frame_valid, bus.atom_ready, bus.overflow, bus.frame_data} !==
                {1'b1, 1'b0, (j > 0), 4'd15, acc_buf}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d] observed=%h expected=%h", j,
                         {bus.frame_valid, bus.atom_ready, bus.overflow, bus.frame_data},
                         {1'b1, 1'b0, (j > 0), 4'd15, acc_buf});
            end
            tick();
        end
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if ({bus.frame_valid, bus.overflow, bus.dct_count} !== {1'b0, 1'b1, 4'd0}) begin
            n_bad++;
            $display("FAIL bp_sticky observed=%h expected=%h",
                     {bus.frame_valid, bus.overflow, bus.dct_count}, {1'b0, 1'b1, 4'd0});
        end
    endtask

    task automatic test_timeout();
        int waited;
        do_reset();
        drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        waited = 0;
        while (bus.frame_valid !== 1'b1 && waited < 50) begin
            #1;
            n_cmp++;
            if (dut_obs() !== m_expect()) begin
                n_bad++;
                $display("FAIL timeout_wait[%0d] observed=%h expected=%h", waited, dut_obs(), m_expect());
            end
            tick();
            waited++;
        end
        n_cmp++;
        if (waited !== TO - 1) begin
            n_bad++;
            $display("FAIL timeout_latency observed=%0d expected=%0d", waited + 1, TO);
        end
        n_cmp++;
        if (bus.frame_data !== {4'd1, 30'h2}) begin
            n_bad++;
            $display("FAIL timeout_frame observed=%h expected=%h", bus.frame_data, {4'd1, 30'h2});
        end
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_disable();
        do_reset();
        drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if ({bus.frame_valid, bus.frame_data} !== {1'b1, 4'd2, 30'h7}) begin
            n_bad++;
            $display("FAIL disable_frame observed=%h expected=%h",
                     {bus.frame_valid, bus.frame_data}, {1'b1, 4'd2, 30'h7});
        end
        tick();
        n_cmp++;
        if (bus.overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL disable_no_ovf observed=%b expected=0", bus.overflow);
        end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
            #1;
            n_cmp++;
            if (bus.frame_valid !== 1'b0 || bus.dct_count !== 4'd0) begin
                n_bad++;
                $display("FAIL empty_flush[%0d] observed=%b/%0d expected=0/0", i,
                         bus.frame_valid, bus.dct_count);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_emit();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if ({bus.frame_valid, bus.overflow} !== 2'b11) begin
            n_bad++;
            $display("FAIL mid_emit_pre observed=%b expected=11", {bus.frame_valid, bus.overflow});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.frame_valid, bus.dct_count, bus.overflow} !== 6'd0) begin
            n_bad++;
            $display("FAIL mid_emit_reset observed=%h expected=0",
                     {bus.frame_valid, bus.dct_count, bus.overflow});
        end
    endtask

    task automatic test_random();
        int busy;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) busy = $urandom_range(1, 6);
            reset = ($urandom_range(0, 299) == 0);
            drive(($urandom_range(0, 15) != 0),
                  ($urandom_range(0, 6) < busy),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 2) == 0));
            #1;
            n_cmp++;
            if (dut_obs() !== m_expect()) begin
                n_bad++;
                $display("FAIL random[%0d] observed=%h expected=%h", c, dut_obs(), m_expect());
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_backpressure();
        test_timeout();
        test_disable();
        test_reset_mid_emit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
